// File: rtl/intr_sequencer_pkg.sv
// Shared definitions for the interrupt entry/exit sequencer: sizes, vector base,
// FSM encoding and a one-hot to index helper.
package intr_sequencer_pkg;

  localparam int N_INTR = 8;
  localparam int ADDR_W = 10;
  localparam int IDX_W  = $clog2(N_INTR);
  localparam int LVL_W  = $clog2(N_INTR + 1);

  localparam logic [ADDR_W-1:0] VEC_BASE = 10'h3E0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_RETURN   = 2'd2
  } seq_state_e;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_INTR-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_INTR; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/intr_stack.sv
// Return-address LIFO. Pop on empty yields 0 and raises underflow for that cycle;
// the top entry is presented combinationally so the caller can register it on pop.
module intr_stack #(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 10,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             underflow_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic             empty;
  logic             full;
  logic [PTR_W-1:0] top_ptr;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign top_ptr = PTR_W'(count_q - CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !full) begin
      mem_q[PTR_W'(count_q)] <= push_data_i;
      count_q                <= count_q + CNT_W'(1);
    end else if (pop_i && !empty) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign pop_data_o  = empty ? '0 : mem_q[top_ptr];
  assign count_o     = count_q;
  assign underflow_o = pop_i && empty;

endmodule

// File: rtl/intr_sequencer.sv
// Interrupt entry/exit sequencer: picks the highest-priority eligible line at an
// instruction boundary, dispatches its vector and unwinds nesting on return.
//
//   state       | meaning
//   ST_IDLE     | waiting for reti or an eligible request at a boundary
//   ST_DISPATCH | take/call_intr/vec_addr presented for one cycle
//   ST_RETURN   | ret_valid/s_return_intr/ret_addr presented for one cycle
module intr_sequencer
  import intr_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [N_INTR-1:0] pending,
  input  logic [N_INTR-1:0] mask,
  input  logic              gie,
  input  logic              boundary,
  input  logic [ADDR_W-1:0] pc_next,
  input  logic              reti,
  output logic              take,
  output logic [ADDR_W-1:0] vec_addr,
  output logic [N_INTR-1:0] call_intr,
  output logic              ret_valid,
  output logic [ADDR_W-1:0] ret_addr,
  output logic [N_INTR-1:0] s_return_intr,
  output logic [N_INTR-1:0] active,
  output logic [3:0]        level,
  output logic              error
);

  seq_state_e        state_q, state_d;
  logic [N_INTR-1:0] active_q, active_d;
  logic              error_q, error_d;
  logic              take_q, take_d;
  logic [N_INTR-1:0] call_q, call_d;
  logic [ADDR_W-1:0] vec_q, vec_d;
  logic              ret_valid_q, ret_valid_d;
  logic [ADDR_W-1:0] ret_addr_q, ret_addr_d;
  logic [N_INTR-1:0] s_ret_q, s_ret_d;

  logic              stk_push, stk_pop, stk_underflow;
  logic [ADDR_W-1:0] stk_top;
  logic [LVL_W-1:0]  stk_count;

  logic [N_INTR-1:0] low_active, allowed, elig, winner;
  logic [IDX_W-1:0]  win_idx;

  // Only lines strictly higher in priority than the current in-service one may preempt.
  assign low_active = active_q & (~active_q + N_INTR'(1));
  assign allowed    = low_active - N_INTR'(1);
  assign elig       = pending & mask & ~active_q & allowed;
  assign winner     = elig & (~elig + N_INTR'(1));
  assign win_idx    = onehot_to_idx(winner);

  intr_stack #(
    .DEPTH (N_INTR),
    .WIDTH (ADDR_W)
  ) u_stack (
    .clk         (clk),
    .reset       (reset),
    .push_i      (stk_push),
    .push_data_i (pc_next),
    .pop_i       (stk_pop),
    .pop_data_o  (stk_top),
    .count_o     (stk_count),
    .underflow_o (stk_underflow)
  );

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    error_d     = error_q;
    take_d      = 1'b0;
    call_d      = '0;
    vec_d       = '0;
    ret_valid_d = 1'b0;
    ret_addr_d  = '0;
    s_ret_d     = '0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (reti) begin
          stk_pop = 1'b1;
          if (stk_underflow) begin
            error_d = 1'b1;
          end else begin
            ret_valid_d = 1'b1;
            ret_addr_d  = stk_top;
            s_ret_d     = low_active;
            active_d    = active_q & ~low_active;
            state_d     = ST_RETURN;
          end
        end else if (gie && boundary && (elig != '0)) begin
          stk_push = 1'b1;
          take_d   = 1'b1;
          call_d   = winner;
          vec_d    = VEC_BASE + ADDR_W'({win_idx, 2'b00});
          active_d = active_q | winner;
          state_d  = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        if (reti) error_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      active_q    <= '0;
      error_q     <= 1'b0;
      take_q      <= 1'b0;
      call_q      <= '0;
      vec_q       <= '0;
      ret_valid_q <= 1'b0;
      ret_addr_q  <= '0;
      s_ret_q     <= '0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      error_q     <= error_d;
      take_q      <= take_d;
      call_q      <= call_d;
      vec_q       <= vec_d;
      ret_valid_q <= ret_valid_d;
      ret_addr_q  <= ret_addr_d;
      s_ret_q     <= s_ret_d;
    end
  end

  assign take          = take_q;
  assign call_intr     = call_q;
  assign vec_addr      = vec_q;
  assign ret_valid     = ret_valid_q;
  assign ret_addr      = ret_addr_q;
  assign s_return_intr = s_ret_q;
  assign active        = active_q;
  assign level         = stk_count;
  assign error         = error_q;

endmodule

// File: doc/intr_sequencer.md
# intr_sequencer

Interrupt entry/exit sequencer for the basic CPU's 8-line interrupt manager. Sits between the request/attention registers and the control unit. Picks the highest-priority eligible request at an instruction boundary, issues the one-hot `call_intr` that sets the attention bit, and hands the CPU a vector address. Also saves and restores return addresses on a nesting stack and issues the one-hot `s_return_intr` that retires the in-service line on return.

## Interface
- `N_INTR`, 8: number of interrupt lines; bit 0 has the highest priority.
- `ADDR_W`, 10: program-counter width.
- `VEC_BASE`, 10'h3E0: vector table base; vector for line i = `VEC_BASE + 4*i`.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `pending` in N_INTR: request-register contents.
- `mask` in N_INTR: per-line enable, 1 = enabled.
- `gie` in 1: global interrupt enable.
- `boundary` in 1: CPU finishes an instruction this cycle.
- `pc_next` in ADDR_W: address of the next instruction, valid with `boundary`.
- `reti` in 1: single-cycle pulse, CPU executes return-from-interrupt.
- `take` out 1: pulse; CPU loads PC from `vec_addr`.
- `vec_addr` out ADDR_W: vector of the dispatched line.
- `call_intr` out N_INTR: one-hot pulse to the attention register.
- `ret_valid` out 1: pulse; CPU loads PC from `ret_addr`.
- `ret_addr` out ADDR_W: popped return address.
- `s_return_intr` out N_INTR: one-hot pulse clearing request and attention for the retired line.
- `active` out N_INTR: in-service vector.
- `level` out 4: nesting depth, 0..8.
- `error` out 1: sticky; set by a return with an empty stack or by `reti` during DISPATCH.

## Operation
- **Priority gate**
  - `allowed = (active & -active) - 1`, evaluated in N_INTR bits. This selects every bit below the lowest active bit; it is all ones when `active` = 0.
  - `elig = pending & mask & ~active & allowed`.
  - Winner = lowest set bit of `elig`.
- **FSM states:** IDLE, DISPATCH, RETURN.
- **IDLE:**
  - If `reti`: pop the stack. Register `ret_addr` = popped value and `s_return_intr` = lowest set bit of `active`. Clear that bit in `active`, decrement `level`, go to RETURN.
  - Else if `gie & boundary & (elig != 0)`: push `pc_next`. Register `call_intr` = winner and `vec_addr` = `VEC_BASE + 4*idx`. Set the winner bit in `active`, increment `level`, go to DISPATCH.
  - `reti` has priority over dispatch in the same cycle. The dispatch is re-evaluated at a later boundary.
- **DISPATCH:** `take` = 1 and `call_intr` valid for exactly this cycle. `boundary` is ignored. `reti` sets `error` and is dropped. Always returns to IDLE.
- **RETURN:** `ret_valid` = 1 and `s_return_intr` valid for exactly this cycle. Always returns to IDLE.
- **Return with empty stack** (`reti` with `level` = 0): set `error`. No pulse, no state change.
- **`gie` = 0** blocks dispatch only; returns proceed normally.
- **Stack** depth equals N_INTR. Each line can be in service only once, so overflow is impossible by construction.
- **Masking a line while it is in service** does not affect its `active` bit.

## Timing
- Registered outputs. Dispatch decision at edge N → `take`/`call_intr`/`vec_addr` high during cycle N to N+1.
- Return decision at edge N → `ret_valid`/`s_return_intr`/`ret_addr` high during cycle N to N+1.
- Minimum spacing between two dispatches is 2 cycles; dispatch followed by return is also at least 2 cycles.
- `active` and `level` update at the decision edge and are visible with the pulse.
- **Reset asserted** (any state, including mid-DISPATCH): immediately forces state IDLE and all outputs to 0; `active`, `level`, `error` and the stack pointer return to 0.
- **Reset release:** first decision is possible on the first rising edge after `reset` goes high.

## Structure
- Shared package holds:
  - FSM state encodings;
  - `N_INTR`, `ADDR_W` and `VEC_BASE` defaults;
  - a one-hot-to-index function.
- The LIFO is a natural sub-module: `intr_stack`. It is parameterised by depth and width, has push/pop ports, exposes a count, and pop-on-empty returns 0 with an `underflow` flag.
- The priority gate stays inline.

## Test plan
- **Reset:**
  - Stimulus: hold `reset` low, drive `pending` = FF.
  - Response: all outputs 0 and `level` = 0.
  - After release with `gie` = 0 and `boundary` pulsing: no `take`.
- **Single dispatch:**
  - Stimulus: `pending` = 04, `mask` = FF, `gie` = 1, `boundary` with `pc_next` = 0x055.
  - Response: next cycle `take` = 1, `call_intr` = 04, `vec_addr` = 0x3E8, `active` = 04, `level` = 1.
- **Simultaneous requests:**
  - Stimulus: `pending` = 28.
  - Response: `call_intr` = 08, `vec_addr` = 0x3EC.
  - With `mask` = F7: `call_intr` = 20.
- **Nesting and unwind:**
  - Stimulus: line 2 in service (`pc_next` = 0x055 at entry); raise bit 5, then bit 1 at `pc_next` = 0x3EA; then two `reti`.
  - Response: bit 5 is not taken; bit 1 is taken with `vec_addr` = 0x3E4 and `level` = 2.
  - First `reti` → `ret_addr` = 0x3EA, `s_return_intr` = 02.
  - Second `reti` → `ret_addr` = 0x055, `s_return_intr` = 04, `level` = 0.
- **Collisions:**
  - `reti` and an eligible boundary in the same cycle → RETURN first, dispatch at the next boundary.
  - `reti` at `level` = 0 → `error` = 1 and no `ret_valid`.
- **Reset mid-operation:** assert `reset` during DISPATCH → `take` drops immediately; `active` = 0, `level` = 0.
